color_wave_scheduler: RTL and testbench
=======================================

Name: color_wave_scheduler

Overview:
- Paces a game's colour waves: counts video frames, samples a five-lane colour row from the LFSR colour randomizer every `period` frames, and issues the row lane by lane to the lane spawner over a valid/ready handshake.
- Rejects a row identical to the previous wave (bounded retries) and sanitises invalid colour codes.
- Sits between the colour randomizer and the playfield lane spawner.

Parameters:
- LANES, 5, number of lanes / colours per row (max 8).
- PERIOD_W, 8, width of the period input.
- MAX_RETRY, 3, max consecutive resamples when the new row equals the last row.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- game_en  in  1  level; high allows waves to be scheduled.
- frame_tick  in  1  one-cycle pulse per video frame.
- period  in  PERIOD_W  frames between waves; 0 treated as 1.
- rand_colors  in  3*LANES  randomizer row; lane i at [3i+2:3i].
- lane_mask  in  LANES  lanes eligible for spawning; bit i = lane i.
- spawn_valid  out  1  spawn request valid.
- spawn_lane  out  3  lane index of request.
- spawn_color  out  3  colour code of request.
- spawn_ready  in  1  spawner accepts request.
- wave_count  out  16  completed waves, wraps 0xFFFF->0.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; spawn_valid, spawn_lane, spawn_color, wave_count and busy = 0; frame counter, retry counter, row register, mask register and last-row register = 0.
- All outputs are registered.
- States: IDLE, COUNT, CAPTURE, ISSUE.
- IDLE: game_en=1 -> COUNT, frame counter cleared.
- COUNT:
  - game_en=0 -> IDLE.
  - On frame_tick, frame counter increments.
  - If counter+1 >= max(period,1) on a tick: counter cleared, -> CAPTURE.
  - period is sampled at each tick, so a change mid-count applies immediately.
- CAPTURE (one sample per cycle; the randomizer advances every clock):
  - game_en=0 -> IDLE.
  - rand_colors == last_row and retry < MAX_RETRY -> retry++, stay in CAPTURE.
  - Otherwise latch rand_colors into the row register and last_row, latch lane_mask, clear retry.
    - Latched mask == 0 -> COUNT; wave not counted, last_row still updated.
    - Latched mask != 0 -> ISSUE, lane pointer at the lowest set mask bit.
  - After MAX_RETRY resamples the duplicate row is accepted.
- Colour sanitising at capture: any lane code 3'b000 or 3'b111 is replaced by 3'b001 (PURPLE). last_row stores the raw, unsanitised row.
- ISSUE:
  - spawn_valid=1, spawn_lane = pointer, spawn_color = sanitised row[pointer].
  - Lane and colour are held stable while valid && !ready.
  - Handshake completes on a cycle where spawn_valid && spawn_ready.
    - More enabled lanes remain: pointer moves to the next higher set mask bit; valid stays high, giving back-to-back issue with no gap.
    - Last enabled lane: spawn_valid drops next cycle, wave_count++. Then -> COUNT if game_en=1, else -> IDLE.
  - frame_tick is ignored and the frame counter held while in ISSUE or CAPTURE.
  - game_en falling during ISSUE does not abort; the wave completes first.
  - lane_mask changes during ISSUE have no effect (latched copy used).
- Latency: tick completing the period at edge N -> CAPTURE at N+1 -> spawn_valid high at N+2 (no retries). Each retry adds one cycle.
- spawn_valid never asserts outside ISSUE. spawn_lane and spawn_color hold their last values when valid is low.
- Reset asserted mid-wave: immediate return to reset values; no partial wave is counted.

Test Plan:
- Reset, game_en=1, period=3, mask=5'b11111, ready tied 1, rows distinct -> spawn_valid rises 2 cycles after the 3rd tick; lanes 0,1,2,3,4 issued on 5 consecutive cycles with the row's colours; wave_count=1.
- period=0, mask=5'b10100, ready=1 -> a wave on every tick; only lanes 2 then 4 are issued; wave_count increments once per tick.
- Row equal to last_row for 5 consecutive samples, MAX_RETRY=3 -> 3 retry cycles, then the duplicate row is issued; spawn_valid delayed by 3 extra cycles.
- ready held 0 for 4 cycles on lane 1 -> lane and colour stable throughout; lane 2 issued the cycle after ready rises. Row lane code 3'b111 -> spawn_color=3'b001.
- Drop game_en mid-ISSUE -> wave completes, wave_count++, then busy=0 and IDLE. Drop game_en in COUNT -> IDLE next cycle, no spawn. mask=0 at capture -> no spawn_valid, wave_count unchanged.
- Assert rst low asynchronously mid-ISSUE -> spawn_valid=0 and wave_count=0 without waiting for a clock edge. After release with game_en=1, the first wave appears `period` ticks later.

Source files
------------

// File: rtl/color_wave_scheduler.sv
// color_wave_scheduler: paces colour waves from frame ticks and issues each row lane by lane to the spawner
module color_wave_scheduler #(
  parameter int LANES     = 5,
  parameter int PERIOD_W  = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_en,
  input  logic                  frame_tick,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [3*LANES-1:0]    rand_colors,
  input  logic [LANES-1:0]      lane_mask,
  output logic                  spawn_valid,
  output logic [2:0]            spawn_lane,
  output logic [2:0]            spawn_color,
  input  logic                  spawn_ready,
  output logic [15:0]           wave_count,
  output logic                  busy
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, ISSUE} state_t;
  state_t               state_q;
  logic [PERIOD_W-1:0]  frame_q;
  logic [RW-1:0]        retry_q;
  logic [3*LANES-1:0]   row_q, last_q, san;
  logic [LANES-1:0]     mask_q;
  logic                 valid_q, busy_q, more;
  logic [2:0]           lane_q, color_q, first_lane, first_color, nxt_lane, nxt_color;
  logic [15:0]          wave_q;
  logic [PERIOD_W-1:0]  per;
  logic                 period_done;
  assign per         = (period == '0) ? PERIOD_W'(1) : period;
  assign period_done = ({1'b0, frame_q} + 1'b1) >= {1'b0, per};
  always_comb begin
    san         = '0;
    first_lane  = '0;
    first_color = '0;
    nxt_lane    = '0;
    nxt_color   = '0;
    more        = 1'b0;
    for (int i = 0; i < LANES; i++)
      san[3*i +: 3] = (rand_colors[3*i +: 3] == 3'b000 || rand_colors[3*i +: 3] == 3'b111) ? 3'b001 : rand_colors[3*i +: 3];
    // scan downwards so the lowest qualifying lane wins
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_mask[i]) begin
        first_lane  = 3'(i);
        first_color = san[3*i +: 3];
      end
      if (mask_q[i] && 3'(i) > lane_q) begin
        nxt_lane  = 3'(i);
        nxt_color = row_q[3*i +: 3];
        more      = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      retry_q <= '0;
      row_q   <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      color_q <= '0;
      wave_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (game_en) begin
          state_q <= COUNT;
          frame_q <= '0;
          busy_q  <= 1'b1;
        end
        COUNT: if (!game_en) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (frame_tick) begin
          frame_q <= period_done ? '0 : frame_q + 1'b1;
          if (period_done) state_q <= CAPTURE;
        end
        CAPTURE: if (!game_en) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          retry_q <= '0;
        end else if (rand_colors == last_q && retry_q < MAXR) begin
          retry_q <= retry_q + 1'b1;
        end else begin
          row_q   <= san;
          last_q  <= rand_colors;
          mask_q  <= lane_mask;
          retry_q <= '0;
          state_q <= (lane_mask == '0) ? COUNT : ISSUE;
          valid_q <= lane_mask != '0;
          if (lane_mask != '0) begin
            lane_q  <= first_lane;
            color_q <= first_color;
          end
        end
        ISSUE: if (valid_q && spawn_ready) begin
          if (more) begin
            lane_q  <= nxt_lane;
            color_q <= nxt_color;
          end else begin
            valid_q <= 1'b0;
            wave_q  <= wave_q + 1'b1;
            state_q <= game_en ? COUNT : IDLE;
            busy_q  <= game_en;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign spawn_valid = valid_q;
  assign spawn_lane  = lane_q;
  assign spawn_color = color_q;
  assign wave_count  = wave_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_color_wave_scheduler.sv
// tb_color_wave_scheduler: table-driven waves plus hand sequences, spawns checked against a scoreboard queue
module tb_color_wave_scheduler;
  logic        clk = 0, rst = 0, game_en = 0, frame_tick = 0, spawn_ready = 1;
  logic [7:0]  period = 0;
  logic [14:0] rand_colors = 0;
  logic [4:0]  lane_mask = 0;
  logic        spawn_valid, busy;
  logic [2:0]  spawn_lane, spawn_color;
  logic [15:0] wave_count;
  int          errors = 0, checks = 0, exp_wc = 0, vcnt = 0, vsave, wsave;
  logic [5:0]  q[$];
  logic [5:0]  exp_s;
  typedef struct {logic [7:0] p; logic [4:0] m; logic [14:0] r; int extra;} vec_t;
  vec_t v[8];

  color_wave_scheduler dut (
    .clk(clk), .rst(rst), .game_en(game_en), .frame_tick(frame_tick), .period(period),
    .rand_colors(rand_colors), .lane_mask(lane_mask), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_color(spawn_color), .spawn_ready(spawn_ready),
    .wave_count(wave_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sanc(input logic [2:0] c);
    return (c == 3'd0 || c == 3'd7) ? 3'd1 : c;
  endfunction

  task automatic push_row(input logic [4:0] m, input logic [14:0] r);
    for (int i = 0; i < 5; i++)
      if (m[i]) q.push_back({3'(i), sanc(r[3*i +: 3])});
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 20 && !spawn_valid; i++) step;
    chk("wait_valid", int'(spawn_valid), 1);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 40 && spawn_valid; i++) step;
    chk("wait_done", int'(spawn_valid), 0);
  endtask

  task automatic tick_once;
    frame_tick = 1;
    step;
    frame_tick = 0;
  endtask

  task automatic run_wave(input logic [7:0] p, input logic [4:0] m, input logic [14:0] r, input int extra);
    int per;
    period = p; lane_mask = m; rand_colors = r;
    push_row(m, r);
    per = (p == 0) ? 1 : int'(p);
    for (int t = 0; t < per; t++) begin
      tick_once;
      if (t < per - 1) begin
        chk("early", int'(spawn_valid), 0);
        step;
      end
    end
    chk("lat_pre", int'(spawn_valid), 0);
    for (int e = 0; e < extra; e++) begin
      step;
      chk("retry", int'(spawn_valid), 0);
    end
    step;
    chk("lat", int'(spawn_valid), int'(m != 0));
    wait_done;
    if (m != 0) exp_wc++;
    chk("wave_count", int'(wave_count), exp_wc & 16'hffff);
  endtask

  always @(negedge clk) begin
    if (rst && spawn_valid) begin
      vcnt++;
      if (spawn_ready) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_spawn: lane %0d colour %0d with nothing expected", spawn_lane, spawn_color);
        end else begin
          exp_s = q.pop_front();
          chk("spawn_lane_colour", int'({spawn_lane, spawn_color}), int'(exp_s));
        end
      end
    end
  end

  initial begin
    v[0] = '{8'd3, 5'b11111, {3'd5, 3'd4, 3'd3, 3'd2, 3'd6}, 0};
    v[1] = '{8'd0, 5'b10100, {3'd7, 3'd1, 3'd0, 3'd2, 3'd3}, 0};
    v[2] = '{8'd0, 5'b10100, {3'd4, 3'd5, 3'd6, 3'd1, 3'd2}, 0};
    v[3] = '{8'd1, 5'b00001, {3'd1, 3'd2, 3'd3, 3'd4, 3'd7}, 0};
    v[4] = '{8'd2, 5'b01010, {3'd0, 3'd6, 3'd3, 3'd5, 3'd1}, 0};
    v[5] = '{8'd1, 5'b00000, {3'd2, 3'd2, 3'd2, 3'd2, 3'd2}, 0};
    v[6] = '{8'd4, 5'b10001, {3'd3, 3'd0, 3'd5, 3'd7, 3'd6}, 0};
    v[7] = '{8'd1, 5'b00110, {3'd3, 3'd0, 3'd5, 3'd7, 3'd6}, 3};
    step; step;
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_wave_count", int'(wave_count), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk) rst = 1;
    step;
    chk("idle_busy", int'(busy), 0);
    game_en = 1;
    step;
    chk("count_busy", int'(busy), 1);
    for (int k = 0; k < 8; k++) run_wave(v[k].p, v[k].m, v[k].r, v[k].extra);
    // stall on lane 1 with a 3'b111 code
    spawn_ready = 0; period = 1; lane_mask = 5'b00111;
    rand_colors = {3'd0, 3'd0, 3'd5, 3'd7, 3'd2};
    push_row(lane_mask, rand_colors);
    tick_once;
    wait_valid;
    chk("stall_lane0", int'(spawn_lane), 0);
    spawn_ready = 1;
    step;
    spawn_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", int'(spawn_valid), 1);
      chk("stall_lane", int'(spawn_lane), 1);
      chk("stall_colour", int'(spawn_color), 1);
      step;
    end
    spawn_ready = 1;
    step;
    chk("after_stall_lane", int'(spawn_lane), 2);
    wait_done;
    exp_wc++;
    chk("stall_wave_count", int'(wave_count), exp_wc);
    // game_en drops mid-issue: wave still completes
    lane_mask = 5'b11111; rand_colors = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    push_row(lane_mask, rand_colors);
    tick_once;
    wait_valid;
    game_en = 0;
    wait_done;
    exp_wc++;
    chk("drop_wave_count", int'(wave_count), exp_wc);
    chk("drop_busy", int'(busy), 0);
    step;
    chk("drop_busy_idle", int'(busy), 0);
    // game_en drops in COUNT
    game_en = 1;
    step;
    chk("recount_busy", int'(busy), 1);
    game_en = 0;
    step;
    chk("count_drop_busy", int'(busy), 0);
    vsave = vcnt; wsave = int'(wave_count);
    rand_colors = {3'd6, 3'd6, 3'd1, 3'd1, 3'd4};
    tick_once; step; step; step;
    chk("no_spawn_idle", vcnt, vsave);
    chk("no_wave_idle", int'(wave_count), wsave);
    // async reset mid-issue
    game_en = 1;
    step;
    lane_mask = 5'b11111; rand_colors = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
    push_row(lane_mask, rand_colors);
    tick_once;
    wait_valid;
    #2 rst = 0;
    #1;
    chk("async_valid", int'(spawn_valid), 0);
    chk("async_wave_count", int'(wave_count), 0);
    chk("async_busy", int'(busy), 0);
    q.delete();
    exp_wc = 0;
    @(negedge clk) rst = 1;
    step;
    run_wave(8'd3, 5'b00011, {3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
